// File: rtl/sintable_arbiter.sv
// Round-robin sharing of one sintable lookup port between NUM_REQ requesters.
// Each lookup carries its requester id through the table latency to the response.
module sintable_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int TABLE_LAT = 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         tbl_addr,
  input  logic [DATA_W-1:0]         tbl_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int DEPTH = TABLE_LAT + 1;

  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]         tbl_addr_q, tbl_addr_d;
  logic [DEPTH-1:0]          tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] gnt_d;
  logic [IDW-1:0]     gnt_id;
  logic               found;
  logic               xfer;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_d  = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt_d[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
    if (!resetN) begin
      gnt_d = '0;
    end
  end

  assign xfer = |gnt_d;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    tbl_addr_d   = tbl_addr_q;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    if (xfer) begin
      rr_ptr_d   = gnt_id;
      tbl_addr_d = req_addr[gnt_id*ADDR_W +: ADDR_W];
    end
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = gnt_id;
    for (int i = 1; i < DEPTH; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    // Last tag stage lines up with the table output.
    if (tag_vld_q[DEPTH-1]) begin
      rsp_valid_d = NUM_REQ'(1) << tag_id_q[DEPTH-1];
      rsp_data_d  = tbl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      tbl_addr_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tbl_addr_q  <= tbl_addr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt       = gnt_d;
  assign tbl_addr  = tbl_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_sintable_arbiter.sv
// Directed bench for sintable_arbiter with a 1-cycle table model
// and a scoreboard of expected responses keyed by due cycle.
module tb_sintable_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [3:0]  gnt;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_q;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] lut [256];

  typedef struct {
    int          due;
    logic [3:0]  vld;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) tbl_q <= lut[tbl_addr];

  sintable_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .TABLE_LAT(1)
  ) dut (
    .clk(clk), .resetN(resetN), .req(req), .req_addr(req_addr),
    .gnt(gnt), .tbl_addr(tbl_addr), .tbl_q(tbl_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [3:0] eg);
    exp_t e;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(eg));
    if (resetN && |(req & eg)) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          e.due  = cyc + 3;
          e.vld  = 4'b0001 << i;
          e.data = lut[req_addr[i*8 +: 8]];
          sb.push_back(e);
        end
      end
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'(e.vld));
      check("rsp_data", 32'(rsp_data), 32'(e.data));
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    if (!resetN) sb.delete();
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) tick(4'b0000);
    check("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    logic [7:0] hold_addr;
    for (int a = 0; a < 256; a++) lut[a] = {8'(a), ~8'(a)};
    lut[8'h40] = 16'hFFFF;
    lut[8'h00] = 16'h0000;
    lut[8'h10] = 16'h61FF;
    lut[8'h80] = 16'h0000;
    lut[8'hFF] = 16'hFA00;

    resetN   = 1'b0;
    req      = '0;
    req_addr = '0;
    @(posedge clk);
    #1;
    tick(4'b0000);
    check("rst_tbl_addr", 32'(tbl_addr), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    resetN = 1'b1;

    // single lookup, response 3 cycles later
    req = 4'b0001;
    req_addr[7:0] = 8'h40;
    tick(4'b0001);
    req = 4'b0000;
    drain();

    // all four held
    req = 4'b1111;
    req_addr = {8'hFF, 8'h80, 8'h10, 8'h00};
    tick(4'b0010);
    tick(4'b0100);
    tick(4'b1000);
    tick(4'b0001);
    tick(4'b0010);
    tick(4'b0100);
    tick(4'b1000);
    tick(4'b0001);
    req = 4'b0000;
    drain();

    // wrap from 1 to 3 then back to 1
    req = 4'b0010;
    tick(4'b0010);
    req = 4'b1010;
    tick(4'b1000);
    tick(4'b0010);
    req = 4'b0000;
    drain();

    // single requester streaming
    req = 4'b0100;
    for (int i = 0; i < 64; i++) begin
      req_addr[23:16] = 8'(i);
      tick(4'b0100);
      check("stream_busy", 32'(busy), 32'(1));
    end
    req = 4'b0000;
    drain();

    // reset with lookups in flight
    req = 4'b1111;
    req_addr = {8'h33, 8'h22, 8'h11, 8'h40};
    tick(4'b1000);
    tick(4'b0001);
    tick(4'b0010);
    resetN = 1'b0;
    tick(4'b0000);
    resetN = 1'b1;
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_rsp", 32'(rsp_valid), 32'(0));
    tick(4'b0001);
    req = 4'b0000;
    drain();

    // idle
    hold_addr = tbl_addr;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000);
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_addr", 32'(tbl_addr), 32'(hold_addr));
    end
    check("final_sb", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
